// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative mult/div datapath: load/step/sign-fix strobes, Hi/Lo write.
// Build option: define MULDIV_DIV0_EXC_EN to trap divide-by-zero through the EXC state.
module muldiv_seq_ctrl #(
    parameter int unsigned ITER  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             divisor_zero,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div0_exc,
    output logic             md_load,
    output logic             md_step,
    output logic             md_sign_fix,
    output logic             hilo_write,
    output logic             hilo_src,
    output logic [CNT_W-1:0] iter_cnt
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_WRITE = 3'd4
`ifdef MULDIV_DIV0_EXC_EN
        ,
        S_EXC   = 3'd5
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic             busy_q, busy_d;
    logic             load_q, load_d;
    logic             step_q, step_d;
    logic             fix_q, fix_d;
    logic             write_q, write_d;
    logic             src_q, src_d;
    logic             div0_trap_c;

`ifdef MULDIV_DIV0_EXC_EN
    logic             exc_q, exc_d;
    assign div0_trap_c = op_q & divisor_zero & (iter_cnt_q == '0);
`else
    logic             unused_divisor_zero;
    assign unused_divisor_zero = divisor_zero;
    assign div0_trap_c         = 1'b0;
`endif

    // Next-state and counter; abort overrides every transition.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        iter_cnt_d = iter_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    op_d    = op;
                end
            end
            S_LOAD: begin
                state_d    = S_ITER;
                iter_cnt_d = '0;
            end
            S_ITER: begin
                if (iter_cnt_q != CNT_LAST) begin
                    iter_cnt_d = iter_cnt_q + CNT_W'(1);
                end
                if (div0_trap_c) begin
`ifdef MULDIV_DIV0_EXC_EN
                    state_d = S_EXC;
`endif
                end else if (iter_cnt_q == CNT_LAST) begin
                    state_d = op_q ? S_FIX : S_WRITE;
                end
            end
            S_FIX:   state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
`ifdef MULDIV_DIV0_EXC_EN
            S_EXC:   state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
        if (state_d == S_IDLE) begin
            iter_cnt_d = '0;
        end
    end

    // Strobes are decoded from the next state so the registered copy is Moore-aligned.
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        load_d  = (state_d == S_LOAD);
        step_d  = (state_d == S_ITER);
        fix_d   = (state_d == S_FIX);
        write_d = (state_d == S_WRITE);
        src_d   = busy_d & op_d;
`ifdef MULDIV_DIV0_EXC_EN
        exc_d   = (state_d == S_EXC);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= 1'b0;
            iter_cnt_q <= '0;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
            step_q     <= 1'b0;
            fix_q      <= 1'b0;
            write_q    <= 1'b0;
            src_q      <= 1'b0;
`ifdef MULDIV_DIV0_EXC_EN
            exc_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            iter_cnt_q <= iter_cnt_d;
            busy_q     <= busy_d;
            load_q     <= load_d;
            step_q     <= step_d;
            fix_q      <= fix_d;
            write_q    <= write_d;
            src_q      <= src_d;
`ifdef MULDIV_DIV0_EXC_EN
            exc_q      <= exc_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = write_q;
    assign hilo_write  = write_q;
    assign md_load     = load_q;
    assign md_step     = step_q;
    assign md_sign_fix = fix_q;
    assign hilo_src    = src_q;
    assign iter_cnt    = iter_cnt_q;
`ifdef MULDIV_DIV0_EXC_EN
    assign div0_exc    = exc_q;
`else
    assign div0_exc    = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Randomized bench for muldiv_seq_ctrl against a phase-counting transaction model.
`timescale 1ns/1ps
module tb_muldiv_seq_ctrl;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 6;
`ifdef MULDIV_DIV0_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             op = 1'b0;
    logic             divisor_zero = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, div0_exc, md_load, md_step, md_sign_fix;
    logic             hilo_write, hilo_src;
    logic [CNT_W-1:0] iter_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: an operation is a sequence of phases counted from its LOAD cycle.
    bit m_act   = 1'b0;
    bit m_op    = 1'b0;
    bit m_exc   = 1'b0;
    bit m_izero = 1'b1;
    int m_ph    = 0;

    always #5 clk = ~clk;

    muldiv_seq_ctrl #(.ITER(ITER), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .divisor_zero (divisor_zero),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .div0_exc     (div0_exc),
        .md_load      (md_load),
        .md_step      (md_step),
        .md_sign_fix  (md_sign_fix),
        .hilo_write   (hilo_write),
        .hilo_src     (hilo_src),
        .iter_cnt     (iter_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    task automatic check_all();
        bit e_load, e_step, e_fix, e_wr, e_exc, has_iter;
        int e_iter;
        e_load = 0; e_step = 0; e_fix = 0; e_wr = 0; e_exc = 0;
        has_iter = m_izero; e_iter = 0;
        if (m_act) begin
            has_iter = 0;
            if (m_exc) begin
                e_exc = 1;
            end else if (m_ph == 0) begin
                e_load = 1;
            end else if (m_ph <= int'(ITER)) begin
                e_step = 1; e_iter = m_ph - 1; has_iter = 1;
            end else if (m_op && m_ph == int'(ITER) + 1) begin
                e_fix = 1; e_iter = int'(ITER) - 1; has_iter = 1;
            end else begin
                e_wr = 1; e_iter = int'(ITER) - 1; has_iter = 1;
            end
        end
        chk("busy", 32'(busy), 32'(m_act));
        chk("md_load", 32'(md_load), 32'(e_load));
        chk("md_step", 32'(md_step), 32'(e_step));
        chk("md_sign_fix", 32'(md_sign_fix), 32'(e_fix));
        chk("hilo_write", 32'(hilo_write), 32'(e_wr));
        chk("done", 32'(done), 32'(e_wr));
        chk("div0_exc", 32'(div0_exc), 32'(e_exc));
        chk("hilo_src", 32'(hilo_src), 32'(m_act & m_op));
        if (has_iter) chk("iter_cnt", 32'(iter_cnt), 32'(e_iter));
    endtask

    // Advance the model by the edge that samples the inputs currently driven.
    task automatic model_step();
        if (abort) begin
            m_act = 0; m_izero = 1;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1; m_ph = 0; m_op = op; m_exc = 0; m_izero = 0;
            end
        end else if (m_exc) begin
            m_act = 0;
        end else if (EXC_EN && m_op && m_ph == 1 && divisor_zero) begin
            m_exc = 1;
        end else if (m_ph == (m_op ? int'(ITER) + 2 : int'(ITER) + 1)) begin
            m_act = 0;
        end else begin
            m_ph++;
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_exc = 0; m_izero = 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // Random traffic: back-to-back ops, starts while busy, div-by-zero, aborts.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            start        = ($urandom_range(0, 5) == 0);
            op           = 1'($urandom_range(0, 1));
            divisor_zero = ($urandom_range(0, 2) == 0);
            abort        = ($urandom_range(0, 149) == 0);
            model_step();
            @(posedge clk);
            #1;
            check_all();
        end

        // Flush, then start a mult and hit async reset mid-ITER.
        start = 1'b0; divisor_zero = 1'b0; abort = 1'b1;
        model_step();
        @(posedge clk); #1; check_all();
        abort = 1'b0; start = 1'b1; op = 1'b0;
        model_step();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1; check_all();
            start = 1'b0;
            model_step();
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_iter_zero", 32'(iter_cnt), 32'd0);
        @(posedge clk); #1; check_all();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            model_step();
            @(posedge clk); #1; check_all();
        end

        // A final directed divide to finish from a known idle state.
        start = 1'b1; op = 1'b1; divisor_zero = 1'b0;
        model_step();
        for (int i = 0; i < int'(ITER) + 6; i++) begin
            @(posedge clk); #1; check_all();
            start = 1'b0;
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
